// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters. A round-robin arbiter
// accepts one operation at a time in IDLE, the operands are held on the ALU
// ports for the EXEC dwell (one cycle, or MUL_CYCLES for multiply), and the
// ALU result is captured into a response register. The response is held in
// RESP until the consumer accepts it.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid / reqN_ready  request handshake for requester N (0/1)
//   reqN_op, reqN_a, reqN_b  ALU control code and operands of requester N
//   alu_control, operand_a/b drive to the shared ALU (0 outside EXEC)
//   alu_result               combinational result returned by the ALU
//   rsp_valid / rsp_ready    response handshake
//   rsp_id                   requester that owns the response
//   rsp_result               captured result
//   rsp_zero                 rsp_result == 0, derived locally
//   rsp_err                  operation code was illegal (above 4'b0110)
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int unsigned MUL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,

    output logic [3:0]  alu_control,
    output logic [31:0] operand_a,
    output logic [31:0] operand_b,
    input  logic [31:0] alu_result,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_MUL        = 4'b0101;
    localparam logic [3:0] OP_LAST_LEGAL = 4'b0110;
    // EXEC lasts (preload + 1) cycles, so multiply preloads MUL_CYCLES-1.
    localparam logic [3:0] MUL_PRELOAD   = 4'(MUL_CYCLES - 32'd1);

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_LAST_LEGAL);
    endfunction

    function automatic logic [3:0] dwell_preload(input logic [3:0] op);
        logic [3:0] pre;
        if (op == OP_MUL) begin
            pre = MUL_PRELOAD;
        end else begin
            pre = 4'd0;
        end
        return pre;
    endfunction

    // State and datapath registers
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last1_q, last1_d;      // 1: req1 was granted last, req0 favoured next
    logic [3:0]  ctl_q, ctl_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic        id_q, id_d;
    logic        err_q, err_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic        rsp_zero_q, rsp_zero_d;
    logic        rsp_err_q, rsp_err_d;

    // Combinational helpers
    logic        idle_s;
    logic        grant0_s;
    logic        grant1_s;
    logic        accept_s;
    logic [3:0]  sel_op_s;
    logic [31:0] sel_a_s;
    logic [31:0] sel_b_s;
    logic [31:0] cap_result_s;

    assign idle_s     = (state_q == ST_IDLE);
    assign req0_ready = idle_s & grant0_s;
    assign req1_ready = idle_s & grant1_s;
    assign accept_s   = idle_s & (grant0_s | grant1_s);

    // An illegal op leaves alu_control at 0, so its ALU output is ignored.
    assign cap_result_s = err_q ? 32'd0 : alu_result;

    assign alu_control = ctl_q;
    assign operand_a   = opa_q;
    assign operand_b   = opb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_err     = rsp_err_q;

    // Round-robin pick: a lone valid wins, a tie goes to the one not granted last.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (req0_valid && (!req1_valid || last1_q)) begin
            grant0_s = 1'b1;
        end else if (req1_valid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Route the granted requester's operation towards the capture registers.
    always_comb begin
        sel_op_s = req0_op;
        sel_a_s  = req0_a;
        sel_b_s  = req0_b;
        if (grant1_s) begin
            sel_op_s = req1_op;
            sel_a_s  = req1_a;
            sel_b_s  = req1_b;
        end else begin
            sel_op_s = req0_op;
            sel_a_s  = req0_a;
            sel_b_s  = req0_b;
        end
    end

    // FSM next-state and datapath next-values; everything holds by default.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last1_d      = last1_q;
        ctl_d        = ctl_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        id_d         = id_q;
        err_d        = err_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_EXEC;
                    last1_d = grant1_s;
                    id_d    = grant1_s;
                    err_d   = !op_is_legal(sel_op_s);
                    ctl_d   = op_is_legal(sel_op_s) ? sel_op_s : 4'd0;
                    opa_d   = sel_a_s;
                    opb_d   = sel_b_s;
                    cnt_d   = op_is_legal(sel_op_s) ? dwell_preload(sel_op_s) : 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_EXEC: begin
                if (cnt_q == 4'd0) begin
                    // Last EXEC cycle: capture and release the ALU ports.
                    state_d      = ST_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_id_d     = id_q;
                    rsp_result_d = cap_result_s;
                    rsp_zero_d   = (cap_result_s == 32'd0);
                    rsp_err_d    = err_q;
                    ctl_d        = 4'd0;
                    opa_d        = 32'd0;
                    opb_d        = 32'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                cnt_d       = 4'd0;
                ctl_d       = 4'd0;
                opa_d       = 32'd0;
                opb_d       = 32'd0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, arbitration pointer and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= 4'd0;
            last1_q      <= 1'b1;
            ctl_q        <= 4'd0;
            opa_q        <= 32'd0;
            opb_q        <= 32'd0;
            id_q         <= 1'b0;
            err_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 32'd0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            last1_q      <= last1_d;
            ctl_q        <= ctl_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            id_q         <= id_d;
            err_q        <= err_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed scenarios followed by randomized traffic. A transaction-level
// reference model predicts, per cycle, which requester is accepted, when the
// response appears (acceptance cycle + latency) and its contents.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int MUL = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  alu_control;
    logic [31:0] operand_a, operand_b, alu_result;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
    logic [31:0] rsp_result;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          cyc = 0;
    bit          m_busy = 1'b0;
    int          m_due = 0;
    bit          m_fav0 = 1'b1;
    bit          p_id, p_err;
    logic [3:0]  p_ctl;
    logic [31:0] p_a, p_b, p_res;
    bit          e_id, e_zero, e_err;
    logic [31:0] e_res;
    bit          acc0, acc1;
    int          gq[$];
    logic [31:0] obs1_res;
    logic        obs1_zero;

    always #5 clk = ~clk;

    alu_arbiter #(.MUL_CYCLES(MUL)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_control(alu_control), .operand_a(operand_a), .operand_b(operand_b),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    // Shared ALU seen by the arbiter.
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a - b;
            4'd4:    return a ^ b;
            4'd5:    return a * b;
            4'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_control, operand_a, operand_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check all outputs at negedge against the model, then advance.
    task automatic tick();
        bit          g0, g1, in_exec, in_resp, legal;
        logic [3:0]  op;
        logic [31:0] a, b;
        @(negedge clk);
        g0 = !m_busy && req0_valid && (!req1_valid || m_fav0);
        g1 = !m_busy && req1_valid && !g0;
        in_exec = m_busy && (cyc < m_due);
        in_resp = m_busy && (cyc >= m_due);
        if (in_resp) begin
            e_id = p_id; e_res = p_res; e_zero = (p_res == 32'd0); e_err = p_err;
        end
        check("req0_ready", req0_ready, g0);
        check("req1_ready", req1_ready, g1);
        check("rsp_valid", rsp_valid, in_resp);
        check("alu_control", alu_control, in_exec ? p_ctl : 4'd0);
        check("operand_a", operand_a, in_exec ? p_a : 32'd0);
        check("operand_b", operand_b, in_exec ? p_b : 32'd0);
        check("rsp_id", rsp_id, e_id);
        check("rsp_result", rsp_result, e_res);
        check("rsp_zero", rsp_zero, e_zero);
        check("rsp_err", rsp_err, e_err);
        if (req0_valid && req0_ready) gq.push_back(0);
        if (req1_valid && req1_ready) gq.push_back(1);
        if (rsp_valid && rsp_id) begin
            obs1_res = rsp_result; obs1_zero = rsp_zero;
        end
        acc0 = g0; acc1 = g1;
        if (in_resp && rsp_ready) begin
            m_busy = 1'b0;
        end else if (g0 || g1) begin
            op = g1 ? req1_op : req0_op;
            a  = g1 ? req1_a : req0_a;
            b  = g1 ? req1_b : req0_b;
            legal  = (op <= 4'd6);
            m_busy = 1'b1;
            p_id   = g1;
            p_err  = !legal;
            p_ctl  = legal ? op : 4'd0;
            p_a    = a;
            p_b    = b;
            p_res  = legal ? alu_fn(op, a, b) : 32'd0;
            m_due  = cyc + ((op == 4'd5) ? (1 + MUL) : 2);
            m_fav0 = g1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse in mid-cycle; outputs must clear at once.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_valid", rsp_valid, 1'b0);
        check("rst_ctl", alu_control, 4'd0);
        check("rst_opa", operand_a, 32'd0);
        check("rst_opb", operand_b, 32'd0);
        check("rst_id", rsp_id, 1'b0);
        check("rst_result", rsp_result, 32'd0);
        check("rst_zero", rsp_zero, 1'b0);
        check("rst_err", rsp_err, 1'b0);
        check("rst_ready0", req0_ready, req0_valid);
        check("rst_ready1", req1_ready, req1_valid && !req0_valid);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_busy = 1'b0; m_fav0 = 1'b1;
        e_id = 1'b0; e_res = 32'd0; e_zero = 1'b0; e_err = 1'b0;
        acc0 = 1'b0; acc1 = 1'b0;
        cyc++;
    endtask

    task automatic rand_req(output logic [3:0] op, output logic [31:0] a, output logic [31:0] b);
        op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
        a  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
        b  = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20)));
    endtask

    initial begin
        rst = 1'b0;
        req0_valid = 1'b0; req0_op = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
        req1_valid = 1'b0; req1_op = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // Single add from req0: result 12 two cycles after acceptance.
        gq.delete();
        req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd5; req0_b = 32'd7;
        tick();
        req0_valid = 1'b0;
        check("add_accepted", gq.size(), 32'd1);
        tick();
        check("add_valid", rsp_valid, 1'b1);
        check("add_id", rsp_id, 1'b0);
        check("add_result", rsp_result, 32'd12);
        check("add_zero", rsp_zero, 1'b0);
        check("add_err", rsp_err, 1'b0);
        tick();

        // Both valid continuously: grants alternate starting with req0.
        do_reset();
        gq.delete();
        obs1_res = 32'hdead_beef; obs1_zero = 1'b0;
        req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd3; req0_b = 32'd4;
        req1_valid = 1'b1; req1_op = 4'b0011; req1_a = 32'd9; req1_b = 32'd9;
        repeat (18) tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rr_count", (gq.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 4 && i < gq.size(); i++) begin
            check("rr_order", gq[i], i % 2);
        end
        check("sub_result", obs1_res, 32'd0);
        check("sub_zero", obs1_zero, 1'b1);
        repeat (4) tick();

        // Multiply from req1: control held for MUL cycles, result at T+1+MUL.
        gq.delete();
        req1_valid = 1'b1; req1_op = 4'b0101; req1_a = 32'd6; req1_b = 32'd7;
        tick();
        req1_valid = 1'b0;
        check("mul_accepted", gq.size(), 32'd1);
        for (int k = 0; k < MUL; k++) begin
            check("mul_ctl", alu_control, 4'b0101);
            check("mul_wait", rsp_valid, 1'b0);
            tick();
        end
        check("mul_valid", rsp_valid, 1'b1);
        check("mul_result", rsp_result, 32'd42);
        tick();

        // Illegal op: control stays 0, error response with zero result.
        req0_valid = 1'b1; req0_op = 4'b1010; req0_a = 32'd77; req0_b = 32'd13;
        tick();
        req0_valid = 1'b0;
        check("ill_ctl", alu_control, 4'd0);
        tick();
        check("ill_valid", rsp_valid, 1'b1);
        check("ill_err", rsp_err, 1'b1);
        check("ill_result", rsp_result, 32'd0);
        check("ill_zero", rsp_zero, 1'b1);
        tick();

        // Back-pressure: response held stable, requesters locked out.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd100; req0_b = 32'd23;
        tick();
        req0_valid = 1'b0;
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        rand_req(req0_op, req0_a, req0_b);
        rand_req(req1_op, req1_a, req1_b);
        #1;
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", rsp_valid, 1'b1);
            check("stall_result", rsp_result, 32'd123);
            check("stall_ready0", req0_ready, 1'b0);
            check("stall_ready1", req1_ready, 1'b0);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        tick();
        tick();

        // Reset in the middle of a multiply: transaction abandoned.
        req1_valid = 1'b1; req1_op = 4'b0101; req1_a = 32'd6; req1_b = 32'd7;
        tick();
        req1_valid = 1'b0;
        check("abort_exec", alu_control, 4'b0101);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            check("abort_novalid", rsp_valid, 1'b0);
            tick();
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (acc0 || !req0_valid) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                rand_req(req0_op, req0_a, req0_b);
            end
            if (acc1 || !req1_valid) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                rand_req(req1_op, req1_a, req1_b);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
